ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter; the send direction opposite ps2_drv (receive only).

---
 rtl/ps2_host_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_host_tx
// Purpose : Host-to-device PS/2 command transmitter.
//           It drives the shared ps2_clk and ps2_data pads through open-drain
//           enables.
// Option  : PS2_TX_WATCHDOG_EN adds a device-clock watchdog. When it fires,
//           the frame ends with done and err asserted.
// Revision: 1.0  initial release
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int c_INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_BITS      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // Pad synchronisers (reset to the released/high level)
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_data_s1, r_data_s2;
  logic w_fall;

  state_t             r_state,   w_state_nxt;
  logic [9:0]         r_shreg,   w_shreg_nxt;
  logic [3:0]         r_bitcnt,  w_bitcnt_nxt;
  logic [c_INH_W-1:0] r_inh_cnt, w_inh_cnt_nxt;
  logic               r_nack,    w_nack_nxt;
  logic               r_clk_oe,  w_clk_oe_nxt;
  logic               r_data_oe, w_data_oe_nxt;
  logic               r_ready,   w_ready_nxt;
  logic               r_busy,    w_busy_nxt;
  logic               r_done,    w_done_nxt;
  logic               r_err,     w_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= ps2_data_in;
      r_data_s2  <= r_data_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

`ifdef PS2_TX_WATCHDOG_EN
  localparam int c_WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

  logic [c_WD_W-1:0] r_wd_cnt;
  logic              w_wd_active;
  logic              w_timeout;

  assign w_wd_active = (r_state == ST_REQ) || (r_state == ST_BITS) ||
                       (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);

  // Counter sits at zero outside the watched states, so REQ entry starts from a reload
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (!w_wd_active || w_fall) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_timeout = w_wd_active && !w_fall && (r_wd_cnt == c_WD_LAST);
`else
  // No watchdog in this build; the parameter stays so both builds share one interface.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bitcnt  <= '0;
      r_inh_cnt <= '0;
      r_nack    <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_inh_cnt <= w_inh_cnt_nxt;
      r_nack    <= w_nack_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_ready   <= w_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bitcnt_nxt  = r_bitcnt;
    w_inh_cnt_nxt = r_inh_cnt;
    w_nack_nxt    = r_nack;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (tx_valid && r_ready) begin
          // Frame image: stop, odd parity, data (LSB shifts out first)
          w_shreg_nxt   = {1'b1, ~^tx_data, tx_data};
          w_bitcnt_nxt  = 4'd0;
          w_inh_cnt_nxt = '0;
          w_nack_nxt    = 1'b0;
          w_clk_oe_nxt  = 1'b1;
          w_state_nxt   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        w_clk_oe_nxt  = 1'b1;
        w_data_oe_nxt = 1'b0;
        if (r_inh_cnt == c_INH_LAST) begin
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b1;
          w_state_nxt   = ST_REQ;
        end else begin
          w_inh_cnt_nxt = r_inh_cnt + 1'b1;
        end
      end

      ST_REQ: begin
        if (w_fall) begin
          w_data_oe_nxt = ~r_shreg[0];
          w_shreg_nxt   = {1'b0, r_shreg[9:1]};
          w_bitcnt_nxt  = 4'd1;
          w_state_nxt   = ST_BITS;
        end
      end

      ST_BITS: begin
        if (w_fall) begin
          w_data_oe_nxt = ~r_shreg[0];
          w_shreg_nxt   = {1'b0, r_shreg[9:1]};
          w_bitcnt_nxt  = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd9) begin
            w_state_nxt = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        if (w_fall) begin
          w_nack_nxt  = r_data_s2;
          w_state_nxt = ST_WAIT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        if (r_clk_s2 && r_data_s2) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = r_nack;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase

`ifdef PS2_TX_WATCHDOG_EN
    if (w_timeout) begin
      w_clk_oe_nxt  = 1'b0;
      w_data_oe_nxt = 1'b0;
      w_done_nxt    = 1'b1;
      w_err_nxt     = 1'b1;
      w_state_nxt   = ST_IDLE;
    end
`endif

    w_ready_nxt = (w_state_nxt == ST_IDLE);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign tx_ready    = r_ready;
  assign tx_busy     = r_busy;
  assign tx_done     = r_done;
  assign tx_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_host_tx
// Purpose : Scoreboard bench for ps2_host_tx with a behavioural PS/2 device.
//           The device sits on wired-AND pads. Honours PS2_TX_WATCHDOG_EN.
// Revision: 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int c_INHIBIT = 16;
  localparam int c_TIMEOUT = 200;
  localparam int c_HALF    = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2_clk_oe, ps2_data_oe, tx_ready, tx_busy, tx_done, tx_err;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       w_clk_pad, w_data_pad;

  assign w_clk_pad  = ~(ps2_clk_oe  | dev_clk_low);
  assign w_data_pad = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (c_INHIBIT),
    .TIMEOUT_CYCLES (c_TIMEOUT)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (w_clk_pad),
    .ps2_data_in (w_data_pad),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       err;
    logic       frame;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] cap_q[$];

  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, done_cyc = 0, cyc = 0;
  int inh_run = 0, inh_last = 0;
  int dev_falls = 0;
  bit dev_active = 1'b0, dev_abort = 1'b0, dev_mute = 1'b0, dev_nack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic expire(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops the scoreboard on every tx_done
  exp_t        mon_e;
  logic [10:0] mon_f;
  always @(negedge clk) begin
    if (ps2_clk_oe) begin
      inh_run++;
    end else if (inh_run != 0) begin
      inh_last = inh_run;
      inh_run  = 0;
    end
    if (tx_err) check("err_with_done", tx_done, 1'b1);
    if (tx_done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_ready", {tx_ready, tx_busy}, 2'b10);
      check("done_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      if (exp_q.size() == 0) begin
        expire("done_unexpected");
      end else begin
        mon_e = exp_q.pop_front();
        check("done_err", tx_err, mon_e.err);
        if (mon_e.frame) begin
          if (cap_q.size() == 0) begin
            expire("frame_missing");
          end else begin
            mon_f = cap_q.pop_front();
            check("line_bits", mon_f, {1'b1, mon_e.par, mon_e.data, 1'b0});
          end
        end
      end
    end
  end

  // Device: start bit seen at the request, 10 sampled bits, then the ack clock
  task automatic dev_frame();
    logic [10:0] f;
    f = '0;
    dev_active = 1'b1;
    f[0] = w_data_pad;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (c_HALF) @(negedge clk);
      f[i] = w_data_pad;
      dev_clk_low = 1'b0;
      dev_falls = i;
      repeat (c_HALF) @(negedge clk);
      if (dev_abort) begin
        dev_active = 1'b0;
        return;
      end
    end
    dev_data_low = !dev_nack;
    repeat (5) @(negedge clk);
    cap_q.push_back(f);
    dev_clk_low = 1'b1;
    repeat (c_HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (10) @(negedge clk);
    dev_data_low = 1'b0;
    dev_active = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!dev_mute && !rst && w_clk_pad && !w_data_pad) dev_frame();
    end
  end

  task automatic send(input logic [7:0] d);
    int k;
    k = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (!tx_ready) begin
      expire("accept");
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start, k;
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt == start) expire(name);
  endtask

  task automatic wait_dev_idle();
    int k;
    k = 0;
    while (dev_active && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (dev_active) expire("device_idle");
  endtask

  initial begin
    int snap, k, t0;
    repeat (3) @(negedge clk);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("rst_flags", {tx_busy, tx_done, tx_err}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_busy", {tx_ready, tx_busy}, 2'b10);

    // 0xED acked: inhibit length and line bits
    exp_q.push_back('{data: 8'hED, par: 1'b1, err: 1'b0, frame: 1'b1});
    send(8'hED);
    wait_done("t1_done");
    check("t1_inhibit_len", inh_last, c_INHIBIT);
    wait_dev_idle();

    // Parity 0 and parity 1 cases
    exp_q.push_back('{data: 8'hF4, par: 1'b0, err: 1'b0, frame: 1'b1});
    send(8'hF4);
    wait_done("t2a_done");
    wait_dev_idle();
    exp_q.push_back('{data: 8'h00, par: 1'b1, err: 1'b0, frame: 1'b1});
    send(8'h00);
    wait_done("t2b_done");
    wait_dev_idle();

    // NACK
    dev_nack = 1'b1;
    exp_q.push_back('{data: 8'hFF, par: 1'b1, err: 1'b1, frame: 1'b1});
    send(8'hFF);
    wait_done("t3_done");
    wait_dev_idle();
    dev_nack = 1'b0;
    @(negedge clk);
    check("t3_pads_released", {w_clk_pad, w_data_pad}, 2'b11);

    // Request held while busy
    exp_q.push_back('{data: 8'hED, par: 1'b1, err: 1'b0, frame: 1'b1});
    exp_q.push_back('{data: 8'hAA, par: 1'b1, err: 1'b0, frame: 1'b1});
    send(8'hED);
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_busy_not_ready", {tx_ready, tx_busy}, 2'b01);
    send(8'hAA);
    wait_done("t4_done");
    wait_dev_idle();
    check("t4_queue_empty", exp_q.size(), 0);

    // Reset mid-frame, with tx_valid in the same cycle
    dev_falls = 0;
    send(8'hF4);
    k = 0;
    while (dev_falls < 5 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (dev_falls < 5) expire("t5_falls");
    snap = done_cnt;
    rst = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'h55;
    dev_abort = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_valid = 1'b0;
    check("t5_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("t5_ready_busy", {tx_ready, tx_busy}, 2'b10);
    @(negedge clk);
    check("t5_not_accepted", tx_busy, 1'b0);
    wait_dev_idle();
    dev_abort = 1'b0;
    repeat (100) @(negedge clk);
    check("t5_no_done", done_cnt, snap);

    // Silent device
    dev_mute = 1'b1;
`ifdef PS2_TX_WATCHDOG_EN
    exp_q.push_back('{data: 8'h55, par: 1'b1, err: 1'b1, frame: 1'b0});
    send(8'h55);
    k = 0;
    while (!ps2_data_oe && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!ps2_data_oe) expire("t6_req");
    t0 = cyc;
    wait_done("t6_done");
    check("t6_wd_latency", done_cyc - t0, c_TIMEOUT);
`else
    t0 = 0;
    send(8'h55);
    snap = done_cnt;
    repeat (500) @(negedge clk);
    check("t6_stays_req", {tx_busy, ps2_clk_oe, ps2_data_oe}, {3'b101} + 32'(t0));
    check("t6_no_done", done_cnt, snap);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_idle", {tx_ready, tx_busy}, 2'b10);
`endif
    dev_mute = 1'b0;

    check("final_exp_empty", exp_q.size(), 0);
    check("final_cap_empty", cap_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
